uart_rx: RTL and testbench

Serial-to-parallel UART receiver, 8N1, LSB first. Companion to the existing UART transmitter on the board's serial port. It synchronises the asynchronous `rx` pin, detects and validates the start bit, and samples the eight data bits and the stop bit at mid-bit. Completed bytes go into a one-entry holding register with a valid/ready handshake toward the packet logic. Framing errors and overruns are flagged with one-cycle pulses.

---
 rtl/uart_rx_if.sv | 35 +++
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx_if
// Description : Byte-delivery bundle between the UART receiver and the packet
//               logic: received byte with valid/ready handshake plus the
//               one-cycle framing-error and overrun status pulses.
//               master : receiver side (drives dout/valid/frame_err/overrun)
//               slave  : consumer side (drives rdy)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
  logic [7:0] dout;
  logic       valid;
  logic       rdy;
  logic       frame_err;
  logic       overrun;

  modport master (
    output dout,
    output valid,
    output frame_err,
    output overrun,
    input  rdy
  );

  modport slave (
    input  dout,
    input  valid,
    input  frame_err,
    input  overrun,
    output rdy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first. Synchronises rx, validates the
//               start bit at mid-bit, samples 8 data bits and the stop bit at
//               mid-bit, and hands completed bytes to a one-entry holding
//               register with a valid/ready handshake.
// Ports       : clk   - system clock, rising edge
//               rst   - synchronous, active-low reset
//               rx    - asynchronous serial input, idle high
//               bus   - uart_rx_if.master: dout, valid, rdy (in),
//                       frame_err and overrun one-cycle pulses
// Parameters  : CLKS_PER_BAUD - clock cycles per bit (>= 4, >= 8 w/ majority)
// Build macro : UART_RX_MAJORITY_EN - 2-of-3 majority vote at each sample
//               point (samples at cnt = 2, 1, 0); otherwise single sample.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BAUD = 13020
) (
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire logic  rx,
  uart_rx_if.master  bus
);

  localparam logic [31:0] c_RELOAD = 32'(CLKS_PER_BAUD - 1);
  localparam logic [31:0] c_HALF   = 32'(CLKS_PER_BAUD / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_hist;
  logic [31:0] r_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;

  logic w_rx_s;
  logic w_fall;
  logic w_tick;
  logic w_sample;
  logic w_accept;

  assign w_rx_s   = r_sync2;
  assign w_fall   = r_hist & ~w_rx_s;
  assign w_tick   = (r_cnt == 32'd0);
  assign w_accept = bus.valid & bus.rdy;

`ifdef UART_RX_MAJORITY_EN
  // r_maj[0] holds rx_s from the cnt==1 cycle, r_maj[1] from cnt==2, so at
  // cnt==0 the vote spans three consecutive synchronised samples.
  logic [1:0] r_maj;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_maj <= 2'b11;
    end else begin
      r_maj <= {r_maj[0], w_rx_s};
    end
  end

  assign w_sample = (r_maj[1] & r_maj[0]) | (r_maj[1] & w_rx_s) |
                    (r_maj[0] & w_rx_s);
`else
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_hist        <= 1'b1;
      r_state       <= S_IDLE;
      r_cnt         <= 32'd0;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'h00;
      bus.dout      <= 8'h00;
      bus.valid     <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      r_sync1       <= rx;
      r_sync2       <= r_sync1;
      r_hist        <= r_sync2;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;

      // Consumption; a byte completing this same cycle overrides below.
      if (w_accept) begin
        bus.valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_cnt     <= c_HALF;
            r_bit_cnt <= 3'd0;
            r_state   <= S_START;
          end
        end

        S_START: begin
          if (w_tick) begin
            r_cnt   <= c_RELOAD;
            // A high line at mid start bit was only a glitch.
            r_state <= w_sample ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end

        S_DATA: begin
          if (w_tick) begin
            r_cnt     <= c_RELOAD;
            r_shift   <= {w_sample, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end

        S_STOP: begin
          if (w_tick) begin
            r_cnt   <= c_RELOAD;
            // Back to IDLE at mid stop bit: half a bit of margin for the
            // next start edge.
            r_state <= S_IDLE;
            if (!w_sample) begin
              bus.frame_err <= 1'b1;
            end else if (!bus.valid || w_accept) begin
              bus.dout  <= r_shift;
              bus.valid <= 1'b1;
            end else begin
              bus.overrun <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx with CLKS_PER_BAUD = 16.
//               Frames are driven on rx; each frame's expected outcome (byte,
//               framing error or overrun, and the cycle it must appear) is
//               queued, and a monitor pops and compares whenever the receiver
//               presents an accepted byte or a status pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 16;
  // Drive of the start bit to stop-sample output: 3 sync/edge cycles, half a
  // bit to the start sample, then nine full bits to the stop sample.
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  localparam int K_BYTE = 0;
  localparam int K_FE   = 1;
  localparam int K_OV   = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;   // -1 = any cycle
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;
  int   cyc = 0;

  int checks   = 0;
  int failures = 0;

  ev_t        q[$];
  bit         model_full = 1'b0;
  logic [7:0] model_held = 8'h00;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BAUD(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic observe(input int kind, input logic [7:0] d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual=kind%0d/%02h@%0d required=none",
               kind, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || (kind == K_BYTE && e.data !== d) ||
          (e.cyc >= 0 && e.cyc != cyc)) begin
        failures++;
        $display("FAIL event actual=kind%0d/%02h@%0d required=kind%0d/%02h@%0d",
                 kind, d, cyc, e.kind, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.frame_err === 1'b1) observe(K_FE, 8'h00);
      if (bus.overrun === 1'b1)   observe(K_OV, 8'h00);
      if (bus.valid === 1'b1 && bus.rdy === 1'b1) observe(K_BYTE, bus.dout);
    end
  end

  // ---------------- reference model ----------------
  // A mid-bit one-cycle inversion fools a single sample but not a 2-of-3 vote.
  function automatic logic [7:0] rx_view(input logic [7:0] b, input bit glitch);
`ifdef UART_RX_MAJORITY_EN
    return b;
`else
    return glitch ? ~b : b;
`endif
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit stop_ok,
                             input bit glitch, input int t0);
    int         t;
    logic [7:0] v;
    t = t0 + LAT;
    v = rx_view(b, glitch);
    if (!stop_ok)          q.push_back('{K_FE, 8'h00, t});
    else if (bus.rdy)      q.push_back('{K_BYTE, v, t});
    else if (model_full)   q.push_back('{K_OV, 8'h00, t});
    else begin
      model_full = 1'b1;
      model_held = v;
    end
  endtask

  task automatic set_rdy(input bit r);
    bus.rdy = r;
    if (r && model_full) begin
      q.push_back('{K_BYTE, model_held, -1});
      model_full = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                            input bit glitch);
    logic v;
    model_frame(b, stop_bit, glitch, cyc);
    for (int j = 0; j < 10; j++) begin
      v = (j == 0) ? 1'b0 : (j == 9) ? stop_bit : b[j-1];
      for (int c = 0; c < CPB; c++) begin
        rx = (glitch && j >= 1 && j <= 8 && c == CPB / 2) ? ~v : v;
        step();
      end
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
    chk({tag, "_dout"}, 32'(bus.dout), 32'h00);
    chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] part;
    bit         ok;
    bus.rdy = 1'b1;
    repeat (3) step();
    chk_reset_values("reset");
    rst = 1'b1;
    idle(20);

    // Single byte with rdy held high.
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(5);
    chk("a5_drained", 32'(q.size()), 32'd0);

    // Back-to-back with rdy low: second byte overruns.
    set_rdy(1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(2);
    chk("ovr_valid_held", 32'(bus.valid), 32'd1);
    chk("ovr_dout_kept", 32'(bus.dout), 32'h00);
    set_rdy(1'b1);
    step();
    chk("valid_falls", 32'(bus.valid), 32'd0);
    idle(10);

    // Framing error, then line held low: no retrigger.
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) step();
    idle(30);
    chk("fe_valid_low", 32'(bus.valid), 32'd0);

    // Short glitch on idle line.
    rx = 1'b0;
    repeat (4) step();
    idle(40);
    chk("glitch_no_event", 32'(q.size()), 32'd0);
    chk("glitch_valid_low", 32'(bus.valid), 32'd0);

    // Mid-bit glitches: clean under majority vote, inverted otherwise.
    send_frame(8'h55, 1'b1, 1'b1);
    idle(5);

    // Randomised frames, occasional bad stop bit.
    for (int i = 0; i < 20; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok, 1'b0);
      idle(int'($urandom_range(ok ? 0 : 1, 12)));
    end
    idle(5);

    // Reset in the middle of data bit 4, then a clean byte.
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(5);
    part = 8'h5A;
    rx = 1'b0;
    repeat (CPB) step();
    for (int j = 0; j < 4; j++) begin
      rx = part[j];
      repeat (CPB) step();
    end
    rx = part[4];
    repeat (CPB / 2) step();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) step();
    chk_reset_values("midreset");
    rst = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(5);

    for (int i = 0; i < 400 && q.size() != 0; i++) step();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
